branch_predictor: RTL and testbench

//  Fetch-side partner of the execute-stage branch decision (opcode/rt/alu_zero -> take_branch).

---
 rtl/branch_predictor_pkg.sv | 28 ++
 rtl/branch_predictor_btb_table.sv | 60 ++++++
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings, widths and
// the saturating 2-bit counter update.
package branch_predictor_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_INIT_DEFAULT = CTR_WNT;

    // Move a 2-bit counter one step towards the actual outcome, holding at the ends.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Tagged branch target buffer: valid/tag/target arrays with an asynchronous
// read port for fetch and a synchronous write port for training.
module btb_table
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = PC_W - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [PC_W-1:0]       rd_target,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [PC_W-1:0]       wr_target
);

    localparam int DEPTH = 2 ** INDEX_BITS;

    logic                valid_q  [DEPTH];
    logic                valid_d  [DEPTH];
    logic [TAG_BITS-1:0] tag_q    [DEPTH];
    logic [TAG_BITS-1:0] tag_d    [DEPTH];
    logic [PC_W-1:0]     target_q [DEPTH];
    logic [PC_W-1:0]     target_d [DEPTH];

    // Fetch read sees the stored contents only, so a same-cycle write is not bypassed.
    always_comb begin
        rd_valid  = valid_q[rd_idx];
        rd_tag    = tag_q[rd_idx];
        rd_target = target_q[rd_idx];
    end

    // Next-state of the arrays: a taken branch overwrites its entry, aliasing included.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
        end
    end

    // Only the valid bits need clearing; tag and target are ignored while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counter BHT plus tagged BTB, with EX-stage
// misprediction detection, redirect and training, and performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] CTR_INIT   = CTR_INIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] branch_count,
    output logic [PC_W-1:0] mispredict_count
);

    localparam int DEPTH    = 2 ** INDEX_BITS;
    localparam int TAG_BITS = PC_W - INDEX_BITS - 2;

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;

    logic                  btb_valid;
    logic [TAG_BITS-1:0]   btb_tag;
    logic [PC_W-1:0]       btb_target;
    logic                  hit;
    logic                  res;
    logic                  btb_wr_en;

    logic [1:0]            ctr_q [DEPTH];
    logic [1:0]            ctr_d [DEPTH];
    logic [PC_W-1:0]       branch_count_q;
    logic [PC_W-1:0]       branch_count_d;
    logic [PC_W-1:0]       mispredict_count_q;
    logic [PC_W-1:0]       mispredict_count_d;

    // Word-aligned PCs leave the low two bits without any role in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx    = if_pc[INDEX_BITS+1:2];
    assign if_tag    = if_pc[PC_W-1:INDEX_BITS+2];
    assign ex_idx    = ex_pc[INDEX_BITS+1:2];
    assign ex_tag    = ex_pc[PC_W-1:INDEX_BITS+2];
    assign res       = ex_valid && ex_is_branch;
    assign btb_wr_en = res && ex_taken;

    btb_table #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_idx),
        .rd_valid  (btb_valid),
        .rd_tag    (btb_tag),
        .rd_target (btb_target),
        .wr_en     (btb_wr_en),
        .wr_idx    (ex_idx),
        .wr_tag    (ex_tag),
        .wr_target (ex_target)
    );

    // Zero-cycle lookup: predict taken only on a BTB hit with a taken-leaning counter.
    always_comb begin
        hit         = btb_valid && (btb_tag == if_tag);
        pred_taken  = hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? btb_target : if_pc + 32'd4;
    end

    // Check the prediction carried from IF against the resolved outcome.
    always_comb begin
        redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
        mispredict  = res && ((ex_pred_taken != ex_taken) ||
                              (ex_taken && (ex_pred_target != ex_target)));
    end

    // Training and performance counter next-state.
    always_comb begin
        ctr_d              = ctr_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (res) begin
            ctr_d[ex_idx]  = sat_update(ctr_q[ex_idx], ex_taken);
            branch_count_d = branch_count_q + 32'd1;
        end
        if (mispredict) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // State registers; reset discards any branch resolving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            ctr_q              <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks;
    int failures;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it if the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one EX-stage slot; valid/branch flags select a real branch or a bubble.
    task automatic applyStimulus(input logic v, input logic br, input logic [31:0] pc,
                                 input logic tk, input logic [31:0] tgt,
                                 input logic ptk, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_is_branch   = br;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic setIdle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Advance past the next rising edge and settle 1 ns after it.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Combinational settle before sampling, well away from any edge.
    task automatic settle();
        #2;
    endtask

    task automatic checkLookup(input string tag, input logic [31:0] pc,
                               input logic expTaken, input logic [31:0] expTarget);
        if_pc = pc;
        settle();
        checkOutput({tag, "_taken"}, {31'b0, pred_taken}, {31'b0, expTaken});
        checkOutput({tag, "_target"}, pred_target, expTarget);
    endtask

    task automatic checkCounts(input string tag, input logic [31:0] expBr, input logic [31:0] expMis);
        checkOutput({tag, "_brcnt"}, branch_count, expBr);
        checkOutput({tag, "_miscnt"}, mispredict_count, expMis);
    endtask

    // Present a resolving branch, check the EX outputs, then clock it in.
    task automatic resolveBranch(input string tag, input logic [31:0] pc, input logic tk,
                                 input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                                 input logic expMis, input logic [31:0] expRedirect);
        applyStimulus(1'b1, 1'b1, pc, tk, tgt, ptk, ptgt);
        settle();
        checkOutput({tag, "_mispred"}, {31'b0, mispredict}, {31'b0, expMis});
        checkOutput({tag, "_redirect"}, redirect_pc, expRedirect);
        stepClock();
        setIdle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        if_pc    = 32'h0040_0000;
        setIdle();
        stepClock();
        stepClock();
        rst = 1'b0;

        // 1: reset state
        checkLookup("t1_reset", 32'h0040_0000, 1'b0, 32'h0040_0004);
        checkOutput("t1_mispred", {31'b0, mispredict}, 32'd0);
        checkCounts("t1", 32'd0, 32'd0);
        checkLookup("t1_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // 2: first taken branch allocates, counter 01 -> 10
        resolveBranch("t2", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014,
                      1'b1, 32'h0040_0100);
        checkLookup("t2_after", 32'h0040_0010, 1'b1, 32'h0040_0100);
        checkCounts("t2", 32'd1, 32'd1);

        // 3: 10 -> 11 (correct), then not-taken x4 down to 00 with saturation
        resolveBranch("t3_tk", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100,
                      1'b0, 32'h0040_0100);
        checkLookup("t3_st", 32'h0040_0010, 1'b1, 32'h0040_0100);
        resolveBranch("t3_nt1", 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100,
                      1'b1, 32'h0040_0014);
        checkLookup("t3_wt", 32'h0040_0010, 1'b1, 32'h0040_0100);
        resolveBranch("t3_nt2", 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100,
                      1'b1, 32'h0040_0014);
        checkLookup("t3_wnt", 32'h0040_0010, 1'b0, 32'h0040_0014);
        resolveBranch("t3_nt3", 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h0040_0014,
                      1'b0, 32'h0040_0014);
        checkLookup("t3_snt", 32'h0040_0010, 1'b0, 32'h0040_0014);
        resolveBranch("t3_nt4", 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h0040_0014,
                      1'b0, 32'h0040_0014);
        checkLookup("t3_sat", 32'h0040_0010, 1'b0, 32'h0040_0014);
        resolveBranch("t3_up", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014,
                      1'b1, 32'h0040_0100);
        checkLookup("t3_up", 32'h0040_0010, 1'b0, 32'h0040_0014);
        checkCounts("t3", 32'd7, 32'd4);

        // 4: alias on index 4 with a different tag overwrites the entry; counter 01 -> 10
        resolveBranch("t4", 32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0114,
                      1'b1, 32'h0040_0200);
        checkLookup("t4_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
        checkLookup("t4_new", 32'h0040_0110, 1'b1, 32'h0040_0200);
        checkCounts("t4", 32'd8, 32'd5);

        // 5a: same-cycle lookup and counter training (10 -> 01)
        if_pc = 32'h0040_0110;
        applyStimulus(1'b1, 1'b1, 32'h0040_0110, 1'b0, 32'h0040_0200, 1'b1, 32'h0040_0200);
        settle();
        checkOutput("t5a_old_taken", {31'b0, pred_taken}, 32'd1);
        checkOutput("t5a_mispred", {31'b0, mispredict}, 32'd1);
        stepClock();
        setIdle();
        checkLookup("t5a_new", 32'h0040_0110, 1'b0, 32'h0040_0114);

        // 5b: same-cycle lookup and BTB allocation on empty index 8
        if_pc = 32'h0040_0020;
        applyStimulus(1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0024);
        settle();
        checkOutput("t5b_old_target", pred_target, 32'h0040_0024);
        stepClock();
        setIdle();
        checkLookup("t5b_new", 32'h0040_0020, 1'b1, 32'h0040_0300);
        checkCounts("t5", 32'd10, 32'd7);

        // 6: correct prediction, target mismatch, and non-branch slots
        resolveBranch("t6_ok", 32'h0040_0020, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300,
                      1'b0, 32'h0040_0300);
        checkCounts("t6_ok", 32'd11, 32'd7);
        resolveBranch("t6_tgt", 32'h0040_0020, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0304,
                      1'b1, 32'h0040_0300);
        checkCounts("t6_tgt", 32'd12, 32'd8);
        applyStimulus(1'b1, 1'b0, 32'h0040_0030, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0034);
        settle();
        checkOutput("t6_nonbr_mispred", {31'b0, mispredict}, 32'd0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 32'h0040_0030, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0034);
        settle();
        checkOutput("t6_inval_mispred", {31'b0, mispredict}, 32'd0);
        stepClock();
        setIdle();
        checkLookup("t6_noalloc", 32'h0040_0030, 1'b0, 32'h0040_0034);
        checkCounts("t6_idle", 32'd12, 32'd8);

        // Reset mid-stream with a branch resolving in the same cycle
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0024);
        stepClock();
        rst = 1'b0;
        setIdle();
        checkLookup("t6_rst_a", 32'h0040_0020, 1'b0, 32'h0040_0024);
        checkLookup("t6_rst_b", 32'h0040_0110, 1'b0, 32'h0040_0114);
        checkCounts("t6_rst", 32'd0, 32'd0);
        resolveBranch("t6_retrain", 32'h0040_0020, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0024,
                      1'b1, 32'h0040_0300);
        checkLookup("t6_retrain", 32'h0040_0020, 1'b1, 32'h0040_0300);
        checkCounts("t6_retrain", 32'd1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
